// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that lets two execute-stage clients share one
// 64-bit add/sub/and/xor ALU, holding each result on a valid/ready response port.
module alu_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
    output logic         rsp_zf,
    output logic         rsp_sf,
    output logic         rsp_of,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zf;
        logic         sf;
        logic         of;
    } alu_out_t;

    function automatic alu_out_t alu_eval(input logic [1:0] op,
                                          input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
        alu_out_t         r;
        logic signed [W-1:0] res;
        r   = '0;
        res = '0;
        case (op)
            2'd0: begin
                res  = a + b;
                r.of = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            2'd1: begin
                res  = a - b;
                r.of = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            2'd2:    res = a & b;
            default: res = a ^ b;
        endcase
        r.result = res;
        r.zf     = (res == '0);
        r.sf     = res[W-1];
        return r;
    endfunction

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                id_q, id_d;
    logic [1:0]          op_q, op_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;
    logic [W-1:0]        rsp_result_q, rsp_result_d;
    logic                rsp_zf_q, rsp_zf_d;
    logic                rsp_sf_q, rsp_sf_d;
    logic                rsp_of_q, rsp_of_d;
    logic                gnt0, gnt1;
    alu_out_t            alu;

    assign alu = alu_eval(op_q, a_q, b_q);

    always_comb begin
        // A lone requester wins; on a tie the one that did not win last time wins.
        gnt0         = req0_valid && (!req1_valid || last_grant_q);
        gnt1         = req1_valid && (!req0_valid || !last_grant_q);
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zf_d     = rsp_zf_q;
        rsp_sf_d     = rsp_sf_q;
        rsp_of_d     = rsp_of_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = gnt0 && rst_n;
                req1_ready = gnt1 && rst_n;
                if (gnt0 || gnt1) begin
                    id_d         = gnt1;
                    op_d         = gnt1 ? req1_op : req0_op;
                    a_d          = gnt1 ? req1_a : req0_a;
                    b_d          = gnt1 ? req1_b : req0_b;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = alu.result;
                rsp_zf_d     = alu.zf;
                rsp_sf_d     = alu.sf;
                rsp_of_d     = alu.of;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
            rsp_of_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zf_q     <= rsp_zf_d;
            rsp_sf_q     <= rsp_sf_d;
            rsp_of_q     <= rsp_of_d;
        end
    end

    // Latched operation is pure data; it is only consumed in EXEC after a fresh accept.
    always_ff @(posedge clk) begin
        id_q <= id_d;
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zf     = rsp_zf_q;
    assign rsp_sf     = rsp_sf_q;
    assign rsp_of     = rsp_of_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [63:0] rsp_result;
    logic        rsp_zf, rsp_sf, rsp_of, busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_of(rsp_of),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
    } ref_t;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU: exact 65-bit signed arithmetic; overflow means the true value does not fit.
    function automatic ref_t ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        ref_t r;
        logic signed [64:0] wide;
        wide = '0;
        r.of = 1'b0;
        case (op)
            2'd0: begin
                wide  = $signed({a[63], a}) + $signed({b[63], b});
                r.res = wide[63:0];
                r.of  = wide[64] ^ wide[63];
            end
            2'd1: begin
                wide  = $signed({a[63], a}) - $signed({b[63], b});
                r.res = wide[63:0];
                r.of  = wide[64] ^ wide[63];
            end
            2'd2:    r.res = a & b;
            default: r.res = a ^ b;
        endcase
        r.zf = (r.res == 64'd0);
        r.sf = r.res[63];
        return r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            4:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'd0; req1_op = 2'd0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        idle_inputs();
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        #1;
        chk1("vec_ready_granted", v.id ? req1_ready : req0_ready, 1'b1);
        chk1("vec_ready_other", v.id ? req0_ready : req1_ready, 1'b0);
        @(negedge clk);
        // Operands change after the accept edge and must not reach the result.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~v.a; req0_b = ~v.b; req1_a = ~v.a; req1_b = ~v.b;
        #1;
        chk1("vec_exec_valid", rsp_valid, 1'b0);
        chk1("vec_exec_busy", busy, 1'b1);
        @(negedge clk);
        #1;
        chk1("vec_rsp_valid", rsp_valid, 1'b1);
        chk1("vec_rsp_id", rsp_id, v.id);
        chk64("vec_rsp_result", rsp_result, v.res);
        chk1("vec_rsp_zf", rsp_zf, v.zf);
        chk1("vec_rsp_sf", rsp_sf, v.sf);
        chk1("vec_rsp_of", rsp_of, v.of);
        @(negedge clk);
        #1;
        chk1("vec_pop_valid", rsp_valid, 1'b0);
        chk1("vec_pop_busy", busy, 1'b0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 2'd3, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F,
                    64'hF0F00F0FF0F00F0F, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 64'h7FFFFFFFFFFFFFFF, 64'd1,
                    64'h8000000000000000, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 2'd1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'd1, 64'h8000000000000000, 64'd1,
                    64'h7FFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 2'd2, 64'hFF00FF00FF00FF00, 64'h0FF00FF00FF00FF0,
                    64'h0F000F000F000F00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'd0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'd1, 64'd0, 64'h8000000000000000,
                    64'h8000000000000000, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        rsp_ready = 1'b0;
        idle_inputs();
        #2;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_ready1", req1_ready, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chk64("rst_rsp_result", rsp_result, 64'd0);
        chk1("rst_flags", rsp_zf | rsp_sf | rsp_of, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Round-robin with both requesters continuously valid.
        begin
            logic q_id[$];
            logic exp_next;
            int   grants;
            do_reset();
            @(negedge clk);
            rsp_ready  = 1'b1;
            req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd100; req0_b = 64'd23;
            req1_valid = 1'b1; req1_op = 2'd3; req1_a = 64'hF0;  req1_b = 64'hFF;
            exp_next = 1'b0;
            grants   = 0;
            for (int c = 0; c < 40 && grants < 4; c++) begin
                #1;
                chk1("rr_not_both_ready", req0_ready & req1_ready, 1'b0);
                if (rsp_valid) begin
                    if (q_id.size() == 0) chk1("rr_rsp_unexpected", 1'b1, 1'b0);
                    else begin
                        logic e;
                        e = q_id.pop_front();
                        chk1("rr_rsp_id", rsp_id, e);
                        chk64("rr_rsp_result", rsp_result, e ? 64'h0F : 64'd123);
                    end
                end
                if (req0_ready | req1_ready) begin
                    chk1("rr_order", req1_ready, exp_next);
                    q_id.push_back(req1_ready);
                    exp_next = ~exp_next;
                    grants++;
                end
                @(negedge clk);
            end
            if (grants < 4) chk1("rr_timeout", 1'b0, 1'b1);
        end

        // Backpressure: response held for 5 cycles with rsp_ready low.
        begin
            int waited;
            do_reset();
            @(negedge clk);
            rsp_ready  = 1'b0;
            req0_valid = 1'b1; req0_op = 2'd1; req0_a = 64'd50; req0_b = 64'd8;
            waited = 0;
            @(negedge clk);
            req1_valid = 1'b1; req1_op = 2'd2; req1_a = '1; req1_b = '1;
            #1;
            while (!rsp_valid && waited < 10) begin
                @(negedge clk);
                #1;
                waited++;
            end
            if (!rsp_valid) chk1("bp_timeout", 1'b0, 1'b1);
            for (int c = 0; c < 5; c++) begin
                chk1("bp_valid", rsp_valid, 1'b1);
                chk64("bp_result", rsp_result, 64'd42);
                chk1("bp_id", rsp_id, 1'b0);
                chk1("bp_busy", busy, 1'b1);
                chk1("bp_ready0", req0_ready, 1'b0);
                chk1("bp_ready1", req1_ready, 1'b0);
                @(negedge clk);
                #1;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            #1;
            chk1("bp_pop_valid", rsp_valid, 1'b0);
            chk1("bp_pop_busy", busy, 1'b0);
            chk1("bp_pop_ready1", req1_ready, 1'b1);
            chk1("bp_pop_ready0", req0_ready, 1'b0);
        end

        // Reset asserted while the operation is in EXEC.
        do_reset();
        @(negedge clk);
        rsp_ready  = 1'b1;
        req1_valid = 1'b1; req1_op = 2'd0; req1_a = 64'd7; req1_b = 64'd9;
        @(negedge clk);
        req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_valid", rsp_valid, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_ready0", req0_ready, 1'b0);
        chk1("mid_rst_ready1", req1_ready, 1'b0);
        chk1("mid_rst_id", rsp_id, 1'b0);
        chk64("mid_rst_result", rsp_result, 64'd0);
        repeat (2) @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk1("mid_rst_no_rsp", rsp_valid, 1'b0);
            chk1("mid_rst_idle", busy, 1'b0);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk1("mid_rst_tie_ready0", req0_ready, 1'b1);
        chk1("mid_rst_tie_ready1", req1_ready, 1'b0);

        // Randomized traffic against a transaction-level model.
        begin
            logic m_pend, m_age, m_last, e_id, g0, g1;
            ref_t e;
            do_reset();
            m_pend = 1'b0; m_age = 1'b0; m_last = 1'b1; e_id = 1'b0;
            e = '{64'd0, 1'b0, 1'b0, 1'b0};
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                req0_valid = ($urandom_range(0, 9) < 6);
                req1_valid = ($urandom_range(0, 9) < 6);
                req0_op = 2'($urandom_range(0, 3));
                req1_op = 2'($urandom_range(0, 3));
                req0_a = pick(); req0_b = pick();
                req1_a = pick(); req1_b = pick();
                rsp_ready = $urandom_range(0, 1) == 1;
                #1;
                g0 = !m_pend && req0_valid && (!req1_valid || m_last);
                g1 = !m_pend && req1_valid && (!req0_valid || !m_last);
                chk1("rnd_ready0", req0_ready, g0);
                chk1("rnd_ready1", req1_ready, g1);
                chk1("rnd_busy", busy, m_pend);
                chk1("rnd_rsp_valid", rsp_valid, m_pend && m_age);
                if (m_pend && m_age) begin
                    chk1("rnd_rsp_id", rsp_id, e_id);
                    chk64("rnd_rsp_result", rsp_result, e.res);
                    chk1("rnd_rsp_zf", rsp_zf, e.zf);
                    chk1("rnd_rsp_sf", rsp_sf, e.sf);
                    chk1("rnd_rsp_of", rsp_of, e.of);
                end
                if (g0 || g1) begin
                    m_pend = 1'b1;
                    m_age  = 1'b0;
                    e_id   = g1;
                    m_last = g1;
                    e = g1 ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
                end else if (m_pend && !m_age) begin
                    m_age = 1'b1;
                end else if (m_pend && rsp_ready) begin
                    m_pend = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 64-bit ALU datapath (add/sub/and/xor). Grants one requester at a time using round-robin, registers operands, evaluates the operation with condition flags, and holds the result on a valid/ready response port until consumed. It sits between the execute-stage clients and the single ALU instance, so one ALU serves both.

## Interface
- W, 64, operand/result width in bits
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_op  input  2  requester 0 opcode: 0 add, 1 sub (a-b), 2 and, 3 xor
- req0_a, req0_b  input  W  requester 0 operands (signed)
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- rsp_valid  output  1  response held valid
- rsp_ready  input  1  consumer takes response
- rsp_id  output  1  requester index that owns the response
- rsp_result  output  W  ALU result
- rsp_zf, rsp_sf, rsp_of  output  1  zero, sign, signed-overflow flags
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is combinational from the valid signals and the last_grant pointer. Only the granted requester's ready is high, and neither ready is high outside IDLE. On req_valid & req_ready, latch op, a, b and the id, update last_grant to the id, and go to EXEC.
- Round-robin: if one requester is valid, grant it. If both are valid, grant the one that is not last_grant. last_grant resets to 1, so requester 0 wins the first tie.
- EXEC: compute the result and flags from the latched operands, register them into the rsp_* registers, assert rsp_valid, and go to RESP. This always takes exactly one cycle.
- RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- Arithmetic: add and sub wrap modulo 2^W.
- ZF = (result == 0). SF = result[W-1].
- OF for add = (a[W-1]==b[W-1]) & (result[W-1]!=a[W-1]).
- OF for sub = (a[W-1]!=b[W-1]) & (result[W-1]!=a[W-1]).
- OF = 0 for and and xor.
- Requester inputs are ignored outside IDLE. A requester may drop valid before it is granted without side effects.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, last_grant=1, busy=0, req0_ready=0, req1_ready=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zf=0, rsp_sf=0, rsp_of=0.
  - After reset, req*_ready follow the combinational grant.
- Latency: accept at edge t, then rsp_valid=1 from edge t+1.
- Pop at edge p (rsp_valid & rsp_ready): IDLE and a new accept are possible at edge p+1.
- Minimum period is 3 cycles per operation when rsp_ready is held high.
- Reset asserted in EXEC or RESP discards the operation; no response is ever produced for it.
- Operands are sampled only at the accept edge. Changes on req*_a/b after that edge do not affect the result.

## Test plan
- Accept and xor: reset, then req0 xor with a=64'hFFFF0000FFFF0000, b=64'h0F0F0F0F0F0F0F0F, rsp_ready=1.
  - Required: req0_ready=1 in the accept cycle, rsp_valid one edge later.
  - rsp_result=64'hF0F00F0FF0F00F0F, rsp_id=0, zf=0, sf=1, of=0.
- Overflow: req1 add with a=64'h7FFFFFFFFFFFFFFF, b=1.
  - Required: result=64'h8000000000000000, sf=1, of=1, zf=0, rsp_id=1.
- Zero and sub overflow:
  - sub a=5, b=5 gives result=0, zf=1, of=0.
  - sub a=64'h8000000000000000, b=1 gives result=64'h7FFFFFFFFFFFFFFF, of=1, sf=0.
- Round-robin: both requesters hold valid continuously with distinct ops, rsp_ready=1.
  - Required: grants alternate 0,1,0,1 (first grant to 0 after reset).
  - Each response id matches its operands, and never both readys high in the same cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - Required: rsp_* stable, busy=1, both readys 0.
  - rsp_ready=1 pops the response, and IDLE/ready return on the next cycle.
- Reset mid-operation: drop rst_n during EXEC, then release.
  - Required: all outputs are at reset values immediately and no response appears.
  - The next tie grants requester 0.
